spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master. Drives the FIR board's SPI_slave-compatible link: one byte per SSEL-low frame.
- Accepts a byte on a valid/ready handshake, shifts it out on MOSI, and captures the simultaneous MISO byte. The captured byte is returned as a one-cycle rx_valid pulse.
- Used by the test harness and by future on-chip controllers that load FIR coefficients and samples into the slave.

Parameters:
- DATA_WIDTH, 8, bits per frame; the slave requires exactly 8.
- HALF_DIV, 8, clk cycles per SCK half-period. Legal minimum is 8, set by the slave's 3-flop input sync plus this block's 2-flop MISO sync.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_WIDTH  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  high only in IDLE; a transfer is accepted on tx_valid && tx_ready.
- rx_data  out  DATA_WIDTH  byte captured from MISO; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in every state except IDLE.
- SCK  out  1  serial clock; idles low.
- MOSI  out  1  serial data out, MSB first.
- MISO  in  1  serial data in; asynchronous, so it passes through a 2-flop sync.
- SSEL  out  1  active-low select; idles high.

Behaviour:
- Reset (async, rst=1): state IDLE, SSEL=1, SCK=0, MOSI=0, rx_data=0, rx_valid=0, busy=0, all counters 0, MISO sync flops 0. Asserting rst mid-frame aborts the frame immediately and emits no rx_valid. After release: tx_ready=1.
- All serial outputs are registered; there is no combinational path from an input to SCK, MOSI or SSEL.
- Divider: counter div_cnt runs 0..HALF_DIV-1 in every non-IDLE state. A tick occurs at HALF_DIV-1, then the counter wraps to 0. The counter is cleared on entry to each state.
- IDLE:
  - On accept, latch tx_data into tx_shift, drive SSEL<=0 and MOSI<=tx_data[MSB], clear bit_cnt, go to SETUP.
  - tx_valid without tx_ready has no effect.
- SETUP: on tick, SCK<=1 (first rising edge), go to XFER.
- XFER, SCK high: on tick, SCK<=0 (falling edge).
  - If bit_cnt < DATA_WIDTH-1: shift tx_shift left, MOSI<=next bit, bit_cnt++.
  - Otherwise go to HOLD.
- XFER, SCK low: on tick, SCK<=1 (rising edge).
- MISO capture: on every cycle in which SCK is driven 0→1, shift the synchronized MISO into rx_shift LSB.
- HOLD: SCK stays 0 and SSEL stays 0. On tick: SSEL<=1, rx_data<=rx_shift, rx_valid<=1 for exactly one cycle, go to GAP.
- GAP: SSEL high for HALF_DIV cycles, then IDLE. This gap guarantees the slave sees an SSEL rising edge and clears its bit counter.
- Timing, with cycle 0 = accept edge, H=HALF_DIV, W=DATA_WIDTH:
  - SSEL falls at cycle 1.
  - Rising edge k (k=0..W-1) at cycle 1+H(1+2k).
  - Falling edge k at cycle 1+H(2+2k).
  - SSEL rises and rx_valid pulses at cycle 1+H(2W+1).
  - tx_ready returns at cycle 1+H(2W+2).
  - Defaults: rx_valid at cycle 137, next accept possible at cycle 145.
- Exactly W rising and W falling SCK edges occur per frame. SCK is never high while SSEL is high.
- tx_data changing after accept has no effect; it was latched at accept.
- No back-to-back frames without GAP. Every byte gets its own SSEL frame.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, XFER, HOLD, GAP);
  - localparam MIN_HALF_DIV=8;
  - the mode constants CPOL=0, CPHA=0.
- One sub-module, spi_clk_div: a div_cnt counter with clear input and tick output, parameterized by HALF_DIV.
- The FSM, the shift registers and the MISO sync stay in spi_master.

Test Plan:
- Loopback, with MISO tied to MOSI and tx_data=8'hA5 → rx_data=8'hA5, rx_valid at cycle 137 for one cycle, 8 SCK rising edges, SSEL low for cycles 1..136.
- Slave pairing, with an SPI_slave model whose DATA is preloaded to 8'h3C. Send 8'hC3, then 8'h5A → slave DATA=8'hC3 after frame 1. Master rx_data=8'h3C after frame 1 and 8'hC3 after frame 2.
- Handshake: hold tx_valid high with 8'h01 then 8'h02 → exactly two frames, tx_ready low from cycle 1 to cycle 144, second accept at cycle 145, no duplicate frame.
- Reset mid-frame: assert rst after the 4th rising edge → SSEL=1, SCK=0, MOSI=0 in the same cycle, no rx_valid. After release, a new 8'hFF loopback frame returns 8'hFF.
- Edge patterns, 8'h00 and 8'hFF loopback → MOSI constant for the whole frame, rx_data equals tx_data. MOSI changes only in cycles where SCK falls or SSEL falls.
- HALF_DIV=16 build → all edge cycles scale per the timing formula (rx_valid at cycle 273).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0, MSB-first SPI master.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      GAP
   } spi_state_t;

   localparam int   MIN_HALF_DIV = 8;
   localparam logic CPOL         = 1'b0;
   localparam logic CPHA         = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: div_cnt runs 0..HALF_DIV-1 and ticks on the last count.
module spi_clk_div #(
   parameter int HALF_DIV = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int             CW   = $clog2(HALF_DIV);
   localparam logic [CW-1:0]  LAST = CW'(HALF_DIV - 1);

   logic [CW-1:0] r_div_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_cnt <= '0;
      end else if (i_clear || (r_div_cnt == LAST)) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   assign o_tick = !i_clear && (r_div_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte per SSEL-low frame, MISO byte returned on an rx_valid pulse.
// Handshake: a byte is accepted on the clock edge where i_tx_valid && o_tx_ready are both high.
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int HALF_DIV   = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_busy,
   output logic                  o_sck,
   output logic                  o_mosi,
   input  logic                  i_miso,
   output logic                  o_ssel,
   output spi_state_t            o_dbg_state
);

   // Never divide faster than the slave's input synchronizer can follow.
   localparam int              HALF     = (HALF_DIV < MIN_HALF_DIV) ? MIN_HALF_DIV : HALF_DIV;
   localparam int              BCW      = $clog2(DATA_WIDTH);
   localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

   spi_state_t            r_state;
   spi_state_t            w_next_state;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic [BCW-1:0]        r_bit_cnt;
   logic                  r_rx_valid;
   logic                  r_sck;
   logic                  r_ssel;
   logic                  r_miso_meta;
   logic                  r_miso_sync;
   logic                  w_tick;
   logic                  w_accept;
   logic                  w_sck_rise;
   logic                  w_sck_fall;
   logic                  w_shift;
   logic                  w_done;

   // Every exit from a busy state happens on a tick, where the counter wraps to 0,
   // so holding it clear in IDLE is enough to start each state from zero.
   spi_clk_div #(.HALF_DIV(HALF)) u_clk_div (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (r_state == IDLE),
      .o_tick  (w_tick)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_sck_rise   = 1'b0;
      w_sck_fall   = 1'b0;
      w_shift      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_tx_valid) begin
               w_accept     = 1'b1;
               w_next_state = SETUP;
            end
         end
         SETUP: begin
            if (w_tick) begin
               w_sck_rise   = 1'b1;
               w_next_state = XFER;
            end
         end
         XFER: begin
            if (w_tick) begin
               if (r_sck) begin
                  w_sck_fall = 1'b1;
                  if (r_bit_cnt < LAST_BIT) begin
                     w_shift = 1'b1;
                  end else begin
                     w_next_state = HOLD;
                  end
               end else begin
                  w_sck_rise = 1'b1;
               end
            end
         end
         HOLD: begin
            if (w_tick) begin
               w_done       = 1'b1;
               w_next_state = GAP;
            end
         end
         GAP: begin
            if (w_tick) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // MOSI is the MSB of the transmit shifter, so it is registered and clears on reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_rx_data   <= '0;
         r_bit_cnt   <= '0;
         r_rx_valid  <= 1'b0;
         r_sck       <= CPOL;
         r_ssel      <= 1'b1;
         r_miso_meta <= 1'b0;
         r_miso_sync <= 1'b0;
      end else begin
         r_miso_meta <= i_miso;
         r_miso_sync <= r_miso_meta;
         r_rx_valid  <= w_done;
         if (w_accept) begin
            r_tx_shift <= i_tx_data;
            r_ssel     <= 1'b0;
            r_bit_cnt  <= '0;
         end
         if (w_sck_rise) begin
            r_sck      <= !CPOL;
            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], r_miso_sync};
         end
         if (w_sck_fall) begin
            r_sck <= CPOL;
         end
         if (w_shift) begin
            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
         end
         if (w_done) begin
            r_ssel    <= 1'b1;
            r_rx_data <= r_rx_shift;
         end
      end
   end

   assign o_tx_ready  = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_sck       = r_sck;
   assign o_mosi      = r_tx_shift[DATA_WIDTH-1];
   assign o_ssel      = r_ssel;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback, slave pairing, handshake, mid-frame reset, HALF_DIV=16 build.
// Cycle c of a frame is the clock edge c after the accept edge (edge 0); values are sampled 1 unit after edges.
module tb_spi_master;
   import spi_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [W-1:0] tx_data8, rx_data8, tx_data16, rx_data16;
   logic         tx_valid8, ready8, rx_valid8, busy8, sck8, mosi8, miso8, ssel8;
   logic         tx_valid16, ready16, rx_valid16, busy16, sck16, mosi16, miso16, ssel16;
   spi_state_t   state8, state16;

   spi_master #(.DATA_WIDTH(W), .HALF_DIV(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data8), .i_tx_valid(tx_valid8),
      .o_tx_ready(ready8), .o_rx_data(rx_data8), .o_rx_valid(rx_valid8), .o_busy(busy8),
      .o_sck(sck8), .o_mosi(mosi8), .i_miso(miso8), .o_ssel(ssel8), .o_dbg_state(state8)
   );

   spi_master #(.DATA_WIDTH(W), .HALF_DIV(16)) dut16 (
      .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data16), .i_tx_valid(tx_valid16),
      .o_tx_ready(ready16), .o_rx_data(rx_data16), .o_rx_valid(rx_valid16), .o_busy(busy16),
      .o_sck(sck16), .o_mosi(mosi16), .i_miso(miso16), .o_ssel(ssel16), .o_dbg_state(state16)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];

   bit   use16 = 1'b0;
   logic loop_mode = 1'b1;
   logic slave_miso;

   assign miso8  = loop_mode ? mosi8 : slave_miso;
   assign miso16 = mosi16;

   logic         ready_m, rx_valid_m, sck_m, mosi_m, ssel_m;
   logic [W-1:0] rx_data_m;
   assign ready_m    = use16 ? ready16    : ready8;
   assign rx_valid_m = use16 ? rx_valid16 : rx_valid8;
   assign rx_data_m  = use16 ? rx_data16  : rx_data8;
   assign sck_m      = use16 ? sck16      : sck8;
   assign mosi_m     = use16 ? mosi16     : mosi8;
   assign ssel_m     = use16 ? ssel16     : ssel8;

   // SPI_slave behaviour: returns its held DATA, and stores the received byte when SSEL rises.
   logic [W-1:0] s_data, s_tx_sh, s_rx_sh;
   logic         s_prev_sck, s_prev_ssel;
   always @(negedge clk) begin
      if (rst) begin
         slave_miso  = 1'b0;
         s_prev_sck  = 1'b0;
         s_prev_ssel = 1'b1;
      end else begin
         if (s_prev_ssel && !ssel8) begin
            s_tx_sh    = s_data;
            slave_miso = s_data[W-1];
         end
         if (!ssel8 && sck8 && !s_prev_sck) s_rx_sh = {s_rx_sh[W-2:0], mosi8};
         if (!ssel8 && !sck8 && s_prev_sck) begin
            s_tx_sh    = {s_tx_sh[W-2:0], 1'b0};
            slave_miso = s_tx_sh[W-1];
         end
         if (!s_prev_ssel && ssel8) s_data = s_rx_sh;
         s_prev_sck  = sck8;
         s_prev_ssel = ssel8;
      end
   end

   // Per-frame observations filled by run_frame.
   int           f_rise[$], f_fall[$], f_rv[$];
   logic [W-1:0] f_rx[$];
   int           f_ssel_fall, f_ssel_rise, f_ready, f_mosi_bad, f_sck_bad, f_mosi_chg;

   task automatic drive_tx(input logic [W-1:0] d, input logic v);
      if (use16) begin
         tx_data16  = d;
         tx_valid16 = v;
      end else begin
         tx_data8  = d;
         tx_valid8 = v;
      end
   endtask

   task automatic run_frame(input logic [W-1:0] tx, input int h);
      logic p_sck, p_ssel, p_mosi;
      int   b;
      f_rise.delete(); f_fall.delete(); f_rv.delete(); f_rx.delete();
      f_ssel_fall = -1; f_ssel_rise = -1; f_ready = -1;
      f_mosi_bad = 0; f_sck_bad = 0; f_mosi_chg = 0;
      @(negedge clk);
      drive_tx(tx, 1'b1);
      b = 0;
      while (ready_m !== 1'b1 && b < 1000) begin
         @(negedge clk);
         b++;
      end
      n_vec++;
      if (b >= 1000) begin
         n_err++;
         $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, expected 1", ready_m, b);
      end
      p_sck = sck_m; p_ssel = ssel_m; p_mosi = mosi_m;
      @(posedge clk); #1;
      drive_tx(8'($urandom), 1'b0);
      for (int n = 0; n < 2*h*(W+2) + 10; n++) begin
         int c;
         c = n + 1;
         if (p_ssel && !ssel_m) f_ssel_fall = c;
         if (!p_ssel && ssel_m && f_ssel_rise < 0) f_ssel_rise = c;
         if (sck_m && !p_sck) f_rise.push_back(c);
         if (!sck_m && p_sck) f_fall.push_back(c);
         if (sck_m && ssel_m) f_sck_bad++;
         if (mosi_m !== p_mosi && !(p_sck && !sck_m) && !(p_ssel && !ssel_m)) f_mosi_bad++;
         if (mosi_m !== p_mosi && !p_ssel && !ssel_m) f_mosi_chg++;
         if (rx_valid_m) begin
            f_rv.push_back(c);
            f_rx.push_back(rx_data_m);
         end
         if (ready_m && f_ready < 0) f_ready = c;
         p_sck = sck_m; p_ssel = ssel_m; p_mosi = mosi_m;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tx_data8 = '0; tx_valid8 = 1'b0; tx_data16 = '0; tx_valid16 = 1'b0;
      s_data = '0; s_tx_sh = '0; s_rx_sh = '0;
      repeat (3) @(negedge clk);
      n_vec++; if (ssel8 !== 1'b1) begin n_err++; $display("FAIL reset_ssel: got %b expected 1", ssel8); end
      n_vec++; if (sck8 !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b expected 0", sck8); end
      n_vec++; if (mosi8 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b expected 0", mosi8); end
      n_vec++; if (rx_data8 !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data8); end
      n_vec++; if (rx_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid8); end
      n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy8); end
      n_vec++; if (ssel16 !== 1'b1) begin n_err++; $display("FAIL reset_ssel16: got %b expected 1", ssel16); end
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (ready8 !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", ready8); end
      n_vec++; if (ready16 !== 1'b1) begin n_err++; $display("FAIL post_reset_ready16: got %b expected 1", ready16); end
   endtask

   task automatic test_loopback(input logic [W-1:0] tx, input int h, input bit const_mosi);
      logic [W-1:0] exp, got;
      int rv_exp, rdy_exp, g;
      loop_mode = 1'b1;
      exp_q.push_back(tx);
      run_frame(tx, h);
      rv_exp  = 1 + h*(2*W + 1);
      rdy_exp = 1 + h*(2*W + 2);
      exp = exp_q.pop_front();
      got = (f_rx.size() > 0) ? f_rx[0] : 'x;
      n_vec++; if (f_rx.size() != 1) begin n_err++; $display("FAIL lb_rx_pulses: got %0d expected 1", f_rx.size()); end
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL lb_rx_data: got %h expected %h", got, exp); end
      n_vec++; if (rx_data_m !== exp) begin n_err++; $display("FAIL lb_rx_hold: got %h expected %h", rx_data_m, exp); end
      g = (f_rv.size() > 0) ? f_rv[0] : -1;
      n_vec++; if (g != rv_exp) begin n_err++; $display("FAIL lb_rv_cycle: got %0d expected %0d", g, rv_exp); end
      n_vec++; if (f_ssel_fall != 1) begin n_err++; $display("FAIL lb_ssel_fall: got %0d expected 1", f_ssel_fall); end
      n_vec++; if (f_ssel_rise != rv_exp) begin n_err++; $display("FAIL lb_ssel_rise: got %0d expected %0d", f_ssel_rise, rv_exp); end
      n_vec++; if (f_ready != rdy_exp) begin n_err++; $display("FAIL lb_ready_cycle: got %0d expected %0d", f_ready, rdy_exp); end
      n_vec++; if (f_rise.size() != W) begin n_err++; $display("FAIL lb_rise_count: got %0d expected %0d", f_rise.size(), W); end
      n_vec++; if (f_fall.size() != W) begin n_err++; $display("FAIL lb_fall_count: got %0d expected %0d", f_fall.size(), W); end
      for (int k = 0; k < W; k++) begin
         g = (k < f_rise.size()) ? f_rise[k] : -1;
         n_vec++; if (g != 1 + h*(1 + 2*k)) begin n_err++; $display("FAIL lb_rise_%0d: got %0d expected %0d", k, g, 1 + h*(1 + 2*k)); end
         g = (k < f_fall.size()) ? f_fall[k] : -1;
         n_vec++; if (g != 1 + h*(2 + 2*k)) begin n_err++; $display("FAIL lb_fall_%0d: got %0d expected %0d", k, g, 1 + h*(2 + 2*k)); end
      end
      n_vec++; if (f_mosi_bad != 0) begin n_err++; $display("FAIL lb_mosi_timing: got %0d stray changes expected 0", f_mosi_bad); end
      n_vec++; if (f_sck_bad != 0) begin n_err++; $display("FAIL lb_sck_ssel: got %0d cycles expected 0", f_sck_bad); end
      if (const_mosi) begin
         n_vec++; if (f_mosi_chg != 0) begin n_err++; $display("FAIL lb_mosi_const: got %0d changes expected 0", f_mosi_chg); end
      end
   endtask

   task automatic test_edge_patterns();
      use16 = 1'b0;
      test_loopback(8'h00, 8, 1'b1);
      test_loopback(8'hFF, 8, 1'b1);
      test_loopback(8'h00, 8, 1'b1);
   endtask

   task automatic test_random();
      use16 = 1'b0;
      for (int i = 0; i < 4; i++) test_loopback(8'($urandom_range(0, 255)), 8, 1'b0);
   endtask

   task automatic test_slave_pairing();
      logic [W-1:0] tx, exp, got;
      use16 = 1'b0;
      loop_mode = 1'b0;
      s_data = 8'h3C;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) tx = 8'hC3;
         else if (i == 1) tx = 8'h5A;
         else begin
            tx = 8'($urandom);
            s_data = 8'($urandom);
         end
         exp_q.push_back(s_data);
         run_frame(tx, 8);
         exp = exp_q.pop_front();
         got = (f_rx.size() > 0) ? f_rx[0] : 'x;
         n_vec++; if (f_rx.size() != 1) begin n_err++; $display("FAIL sl_rx_pulses_%0d: got %0d expected 1", i, f_rx.size()); end
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL sl_master_rx_%0d: got %h expected %h", i, got, exp); end
         n_vec++; if (s_data !== tx) begin n_err++; $display("FAIL sl_slave_data_%0d: got %h expected %h", i, s_data, tx); end
      end
      loop_mode = 1'b1;
   endtask

   task automatic test_back_to_back();
      int first_low, last_low, second, falls, c, g;
      logic p_ssel;
      bit drop;
      logic [W-1:0] got[$];
      int rv_c[$];
      logic [W-1:0] exp;
      use16 = 1'b0; loop_mode = 1'b1;
      first_low = -1; last_low = -1; second = -1; falls = 0; drop = 1'b0;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      @(negedge clk);
      tx_data8 = 8'h01; tx_valid8 = 1'b1;
      n_vec++; if (ready8 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_idle: got %b expected 1", ready8); end
      p_ssel = ssel8;
      @(posedge clk); #1;
      tx_data8 = 8'h02;
      for (int n = 0; n < 400; n++) begin
         c = n + 1;
         if (drop) begin
            tx_valid8 = 1'b0;
            drop = 1'b0;
         end
         if (!ready8 && second < 0) begin
            if (first_low < 0) first_low = c;
            last_low = c;
         end
         if (ready8 && second < 0 && first_low > 0) begin
            second = c;
            drop = 1'b1;
         end
         if (p_ssel && !ssel8) falls++;
         if (rx_valid8) begin
            got.push_back(rx_data8);
            rv_c.push_back(c);
         end
         p_ssel = ssel8;
         @(posedge clk); #1;
      end
      n_vec++; if (first_low != 1) begin n_err++; $display("FAIL b2b_ready_low_start: got %0d expected 1", first_low); end
      n_vec++; if (last_low != 144) begin n_err++; $display("FAIL b2b_ready_low_end: got %0d expected 144", last_low); end
      n_vec++; if (second != 145) begin n_err++; $display("FAIL b2b_second_accept: got %0d expected 145", second); end
      n_vec++; if (falls != 2) begin n_err++; $display("FAIL b2b_frames: got %0d expected 2", falls); end
      n_vec++; if (got.size() != 2) begin n_err++; $display("FAIL b2b_rx_pulses: got %0d expected 2", got.size()); end
      for (int i = 0; i < 2; i++) begin
         exp = exp_q.pop_front();
         n_vec++;
         if (i >= got.size() || got[i] !== exp) begin
            n_err++;
            $display("FAIL b2b_rx_%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp);
         end
      end
      g = (rv_c.size() > 1) ? rv_c[1] : -1;
      n_vec++; if (g != 282) begin n_err++; $display("FAIL b2b_rv2_cycle: got %0d expected 282", g); end
   endtask

   task automatic test_reset_mid_frame();
      int rises, b, rv;
      logic p_sck;
      use16 = 1'b0; loop_mode = 1'b1;
      rises = 0; b = 0; rv = 0;
      @(negedge clk);
      tx_data8 = 8'h96; tx_valid8 = 1'b1;
      @(posedge clk); #1;
      tx_valid8 = 1'b0;
      p_sck = sck8;
      while (rises < 4 && b < 200) begin
         @(posedge clk); #1;
         b++;
         if (sck8 && !p_sck) rises++;
         if (rx_valid8) rv++;
         p_sck = sck8;
      end
      n_vec++; if (rises != 4) begin n_err++; $display("FAIL rm_rises: got %0d expected 4", rises); end
      n_vec++; if (mosi8 !== 1'b1) begin n_err++; $display("FAIL rm_mosi_bit4: got %b expected 1", mosi8); end
      rst = 1'b1;
      #1;
      n_vec++; if (ssel8 !== 1'b1) begin n_err++; $display("FAIL rm_ssel: got %b expected 1", ssel8); end
      n_vec++; if (sck8 !== 1'b0) begin n_err++; $display("FAIL rm_sck: got %b expected 0", sck8); end
      n_vec++; if (mosi8 !== 1'b0) begin n_err++; $display("FAIL rm_mosi: got %b expected 0", mosi8); end
      n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b expected 0", busy8); end
      repeat (3) begin
         @(negedge clk);
         if (rx_valid8) rv++;
      end
      rst = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (rx_valid8) rv++;
      end
      n_vec++; if (rv != 0) begin n_err++; $display("FAIL rm_no_rx_valid: got %0d pulses expected 0", rv); end
      n_vec++; if (ready8 !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b expected 1", ready8); end
      test_loopback(8'hFF, 8, 1'b1);
   endtask

   task automatic test_half_div16();
      use16 = 1'b1;
      test_loopback(8'($urandom_range(0, 255)), 16, 1'b0);
      test_loopback(8'h81, 16, 1'b0);
      use16 = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_loopback(8'hA5, 8, 1'b0);
      test_edge_patterns();
      test_random();
      test_slave_pairing();
      test_back_to_back();
      test_reset_mid_frame();
      test_half_div16();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
